point_operation_p: RTL and testbench
====================================

POINT_OPERATION_P -- requirements
Module: point_operation_p

Interface
REQ-001 SHALL have parameter WIDTH, default 256, operand/field width in bits.
REQ-002 SHALL have parameter AUTO_DOUBLE, default 1, meaning add mode reroutes P1==P2 to the doubling path.
REQ-003 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_start  in  1  one-cycle operation request.
- i_double  in  1  0 = add P1+P2, 1 = double 2*P1; sampled with i_start.
- i_a, i_p  in  WIDTH  curve coefficient a, prime modulus p.
- i_x1, i_y1, i_x2, i_y2  in  WIDTH  affine coordinates.
- i_inf1, i_inf2  in  1  1 = corresponding point is infinity.
- o_busy  out  1  operation in progress.
- o_done  out  1  one-cycle completion pulse.
- o_x, o_y  out  WIDTH  result coordinates, held until next completion.
- o_inf  out  1  result is infinity.
- o_mod_mul_start, o_mod_div_start  out  1  one-cycle requests to modular unit (a*b mod p, a/b mod p).
- o_mod_a, o_mod_b  out  WIDTH  modular unit operands, stable from request until i_mod_finish.
- i_mod_result  in  WIDTH  modular unit result.
- i_mod_finish  in  1  modular unit result valid, one cycle.

Function
REQ-004 SHALL latch i_double, i_a, i_p, coordinates and inf flags on the cycle i_start is accepted; later input changes SHALL not affect the operation.
REQ-005 SHALL accept i_start only in IDLE; i_start while o_busy=1 SHALL be ignored.
REQ-006 SHALL implement states IDLE, CHECK, LAM_MUL, LAM_DIV, X_MUL, Y_MUL, DONE; o_busy=1 in every state except IDLE.
REQ-007 IDLE->CHECK on accepted i_start.
REQ-008 CHECK special cases, each going directly to DONE without any modular request: add: inf1&inf2 -> infinity; inf1 -> result P2; inf2 -> result P1; x1==x2 and (y1!=y2 or y1==0) -> infinity; double: inf1 or y1==0 -> infinity.
REQ-009 CHECK, add, x1==x2, y1==y2, y1!=0: AUTO_DOUBLE=1 -> doubling path; AUTO_DOUBLE=0 -> infinity.
REQ-010 Doubling path SHALL issue mul (3*x1 mod p, x1) in LAM_MUL, then div ((r+a) mod p, 2*y1 mod p) in LAM_DIV.
REQ-011 Add path SHALL issue div ((y2-y1) mod p, (x2-x1) mod p) in LAM_DIV.
REQ-012 On LAM_DIV finish SHALL store lambda, issue mul (lambda, lambda), enter X_MUL; on finish x3 = (r - x1 - x2) mod p, where x2 := x1 on the doubling path.
REQ-013 Y_MUL SHALL issue mul (lambda, (x1-x3) mod p); on finish y3 = (r - y1) mod p; enter DONE.
REQ-014 Each modular request SHALL be exactly one cycle, issued on the cycle after entering the requesting state; at most one request outstanding.
REQ-015 All modular add/sub SHALL use WIDTH+2-bit intermediates with conditional subtract/add of p, giving results in [0,p) for reduced inputs (<p); unreduced inputs are unsupported.
REQ-016 DONE SHALL update o_x, o_y, o_inf, pulse o_done for one cycle, return to IDLE; an infinity result SHALL drive o_x=o_y=0.
REQ-017 Special-case latency: o_done asserted 2 cycles after the i_start cycle.
REQ-018 i_mod_finish outside a waiting state SHALL be ignored.

Reset
REQ-019 rst=1 SHALL immediately force IDLE and clear o_busy, o_done, o_x, o_y, o_inf, o_mod_mul_start, o_mod_div_start, o_mod_a, o_mod_b, lambda and temporaries to 0.
REQ-020 Reset mid-operation SHALL abandon the operation with no o_done; a late i_mod_finish after reset release SHALL be ignored.

Verification (p=97, a=2, behavioural modular unit with random 1-20 cycle latency)
REQ-021 Double P1=(3,6) -> o_x=80, o_y=10, o_inf=0, one o_done pulse.
REQ-022 Add (3,6)+(80,10) -> (80,87); then add (80,87)+(80,10) -> o_inf=1, o_x=o_y=0, o_done 2 cycles after i_start, no modular request.
REQ-023 Add (3,6)+(3,6) with AUTO_DOUBLE=1 -> (80,10); AUTO_DOUBLE=0 -> o_inf=1.
REQ-024 Add with i_inf1=1, P2=(80,10) -> (80,10), o_inf=0; double with y1=0 -> o_inf=1.
REQ-025 i_start re-pulsed and inputs changed while busy -> ignored, original result delivered; rst=1 during X_MUL -> outputs 0, no o_done, following operation correct.

Source files
------------

// File: rtl/point_operation_p.sv
// Affine elliptic-curve point add/double sequencer over GF(p).
// Field mul/div run on an external modular unit; add/sub are done locally.
module point_operation_p #(
    parameter int WIDTH       = 256,
    parameter int AUTO_DOUBLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_double,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_p,
    input  logic [WIDTH-1:0] i_x1,
    input  logic [WIDTH-1:0] i_y1,
    input  logic [WIDTH-1:0] i_x2,
    input  logic [WIDTH-1:0] i_y2,
    input  logic             i_inf1,
    input  logic             i_inf2,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_x,
    output logic [WIDTH-1:0] o_y,
    output logic             o_inf,
    output logic             o_mod_mul_start,
    output logic             o_mod_div_start,
    output logic [WIDTH-1:0] o_mod_a,
    output logic [WIDTH-1:0] o_mod_b,
    input  logic [WIDTH-1:0] i_mod_result,
    input  logic             i_mod_finish
);

    // state   | meaning
    // IDLE    | waiting for i_start
    // CHECK   | classify operands, resolve special cases
    // LAM_MUL | doubling: wait for 3*x1*x1
    // LAM_DIV | wait for lambda = num / den
    // X_MUL   | wait for lambda^2
    // Y_MUL   | wait for lambda*(x1-x3)
    // DONE    | publish result, pulse o_done
    typedef enum logic [2:0] {
        IDLE, CHECK, LAM_MUL, LAM_DIV, X_MUL, Y_MUL, DONE
    } state_t;

    state_t state, nxt;

    logic [WIDTH-1:0] a_q, p_q, x1_q, y1_q, x2_q, y2_q, lam_q, x3_q;
    logic             dbl_q, inf1_q, inf2_q, path_dbl_q, waiting_q;

    logic             issue_mul, issue_div, ld_done, res_inf, go_dbl, fin;
    logic [WIDTH-1:0] op_a, op_b, res_x, res_y, x3_d;

    function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [WIDTH-1:0] m);
        logic [WIDTH+1:0] s;
        s = {2'b00, a} + {2'b00, b};
        if (s >= {2'b00, m}) s = s - {2'b00, m};
        return WIDTH'(s);
    endfunction

    function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [WIDTH-1:0] m);
        logic [WIDTH+1:0] d;
        d = {2'b00, a} - {2'b00, b};
        if (d[WIDTH+1]) d = d + {2'b00, m};
        return WIDTH'(d);
    endfunction

    assign o_busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt       = state;
        issue_mul = 1'b0;
        issue_div = 1'b0;
        op_a      = '0;
        op_b      = '0;
        ld_done   = 1'b0;
        res_x     = '0;
        res_y     = '0;
        res_inf   = 1'b0;
        go_dbl    = 1'b0;
        // a finish is only meaningful while our own request is pending
        fin       = i_mod_finish & waiting_q;
        x3_d      = mod_sub(mod_sub(i_mod_result, x1_q, p_q),
                            path_dbl_q ? x1_q : x2_q, p_q);
        case (state)
            IDLE: if (i_start) nxt = CHECK;
            CHECK: begin
                if (dbl_q) begin
                    if (inf1_q || y1_q == '0) begin
                        nxt = DONE; ld_done = 1'b1; res_inf = 1'b1;
                    end else begin
                        go_dbl = 1'b1;
                    end
                end else if (inf1_q && inf2_q) begin
                    nxt = DONE; ld_done = 1'b1; res_inf = 1'b1;
                end else if (inf1_q) begin
                    nxt = DONE; ld_done = 1'b1; res_x = x2_q; res_y = y2_q;
                end else if (inf2_q) begin
                    nxt = DONE; ld_done = 1'b1; res_x = x1_q; res_y = y1_q;
                end else if (x1_q == x2_q) begin
                    if (y1_q != y2_q || y1_q == '0 || AUTO_DOUBLE == 0) begin
                        nxt = DONE; ld_done = 1'b1; res_inf = 1'b1;
                    end else begin
                        go_dbl = 1'b1;
                    end
                end else begin
                    nxt       = LAM_DIV;
                    issue_div = 1'b1;
                    op_a      = mod_sub(y2_q, y1_q, p_q);
                    op_b      = mod_sub(x2_q, x1_q, p_q);
                end
                if (go_dbl) begin
                    nxt       = LAM_MUL;
                    issue_mul = 1'b1;
                    op_a      = mod_add(mod_add(x1_q, x1_q, p_q), x1_q, p_q);
                    op_b      = x1_q;
                end
            end
            LAM_MUL: if (fin) begin
                nxt       = LAM_DIV;
                issue_div = 1'b1;
                op_a      = mod_add(i_mod_result, a_q, p_q);
                op_b      = mod_add(y1_q, y1_q, p_q);
            end
            LAM_DIV: if (fin) begin
                nxt       = X_MUL;
                issue_mul = 1'b1;
                op_a      = i_mod_result;
                op_b      = i_mod_result;
            end
            X_MUL: if (fin) begin
                nxt       = Y_MUL;
                issue_mul = 1'b1;
                op_a      = lam_q;
                op_b      = mod_sub(x1_q, x3_d, p_q);
            end
            Y_MUL: if (fin) begin
                nxt     = DONE;
                ld_done = 1'b1;
                res_x   = x3_q;
                res_y   = mod_sub(i_mod_result, y1_q, p_q);
            end
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0; p_q <= '0; x1_q <= '0; y1_q <= '0; x2_q <= '0; y2_q <= '0;
            lam_q <= '0; x3_q <= '0;
            dbl_q <= 1'b0; inf1_q <= 1'b0; inf2_q <= 1'b0;
            path_dbl_q <= 1'b0; waiting_q <= 1'b0;
            o_done <= 1'b0; o_x <= '0; o_y <= '0; o_inf <= 1'b0;
            o_mod_mul_start <= 1'b0; o_mod_div_start <= 1'b0;
            o_mod_a <= '0; o_mod_b <= '0;
        end else begin
            if (state == IDLE && i_start) begin
                dbl_q  <= i_double;
                a_q    <= i_a;
                p_q    <= i_p;
                x1_q   <= i_x1;
                y1_q   <= i_y1;
                x2_q   <= i_x2;
                y2_q   <= i_y2;
                inf1_q <= i_inf1;
                inf2_q <= i_inf2;
            end
            if (state == CHECK) path_dbl_q <= go_dbl;
            if (state == LAM_DIV && fin) lam_q <= i_mod_result;
            if (state == X_MUL && fin) x3_q <= x3_d;

            o_mod_mul_start <= issue_mul;
            o_mod_div_start <= issue_div;
            if (issue_mul || issue_div) begin
                o_mod_a <= op_a;
                o_mod_b <= op_b;
            end
            if (issue_mul || issue_div) waiting_q <= 1'b1;
            else if (fin)               waiting_q <= 1'b0;

            o_done <= ld_done;
            if (ld_done) begin
                o_x   <= res_x;
                o_y   <= res_y;
                o_inf <= res_inf;
            end
        end
    end

endmodule

// File: tb/tb_point_operation_p.sv
// Directed bench for point_operation_p on y^2 = x^3 + 2x + b over GF(97),
// with a behavioural modular mul/div unit of random 1-20 cycle latency.
module tb_point_operation_p;
    localparam int W = 8;
    localparam int P = 97;
    localparam int A = 2;

    logic         clk, rst, start0, start1, dbl, inf1, inf2;
    logic [W-1:0] a_c, p_c, x1, y1, x2, y2;
    logic         busy0, done0, oinf0, mul0, div0;
    logic [W-1:0] ox0, oy0, ma0, mb0;
    logic         busy1, done1, oinf1, mul1, div1;
    logic [W-1:0] ox1, oy1, ma1, mb1;
    logic [W-1:0] mod_result, zero_w;
    logic         mod_finish, zero_b;

    int checks = 0;
    int failures = 0;
    int req_cnt = 0;
    int u1_reqs = 0;

    point_operation_p #(.WIDTH(W), .AUTO_DOUBLE(1)) u0 (
        .clk(clk), .rst(rst), .i_start(start0), .i_double(dbl),
        .i_a(a_c), .i_p(p_c), .i_x1(x1), .i_y1(y1), .i_x2(x2), .i_y2(y2),
        .i_inf1(inf1), .i_inf2(inf2), .o_busy(busy0), .o_done(done0),
        .o_x(ox0), .o_y(oy0), .o_inf(oinf0),
        .o_mod_mul_start(mul0), .o_mod_div_start(div0),
        .o_mod_a(ma0), .o_mod_b(mb0),
        .i_mod_result(mod_result), .i_mod_finish(mod_finish));

    point_operation_p #(.WIDTH(W), .AUTO_DOUBLE(0)) u1 (
        .clk(clk), .rst(rst), .i_start(start1), .i_double(dbl),
        .i_a(a_c), .i_p(p_c), .i_x1(x1), .i_y1(y1), .i_x2(x2), .i_y2(y2),
        .i_inf1(inf1), .i_inf2(inf2), .o_busy(busy1), .o_done(done1),
        .o_x(ox1), .o_y(oy1), .o_inf(oinf1),
        .o_mod_mul_start(mul1), .o_mod_div_start(div1),
        .o_mod_a(ma1), .o_mod_b(mb1),
        .i_mod_result(zero_w), .i_mod_finish(zero_b));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int modinv(input int b);
        for (int i = 1; i < P; i++)
            if ((b * i) % P == 1) return i;
        return 0;
    endfunction

    always @(negedge clk) if (mul1 || div1) u1_reqs++;

    // behavioural modular unit attached to u0
    initial begin
        mod_finish = 1'b0;
        mod_result = '0;
        forever begin
            @(negedge clk);
            mod_finish = 1'b0;
            if (mul0 || div0) begin
                int ca, cb, r, lat;
                logic is_mul;
                ca = int'(ma0);
                cb = int'(mb0);
                is_mul = mul0;
                req_cnt++;
                r = is_mul ? (ca * cb) % P : (ca * modinv(cb)) % P;
                lat = int'($urandom_range(1, 20));
                for (int k = 0; k < lat; k++) begin
                    @(negedge clk);
                    check("mod_request_single_outstanding", int'(mul0 || div0), 0);
                end
                if (!rst && busy0) begin
                    check("mod_operand_a_stable", int'(ma0), ca);
                    check("mod_operand_b_stable", int'(mb0), cb);
                end
                mod_result = W'(r);
                mod_finish = 1'b1;
            end
        end
    end

    task automatic drive(input int d, input int xa, input int ya, input int xb,
                         input int yb, input int fa, input int fb);
        dbl  = (d != 0);
        x1   = W'(xa);
        y1   = W'(ya);
        x2   = W'(xb);
        y2   = W'(yb);
        inf1 = (fa != 0);
        inf2 = (fb != 0);
    endtask

    task automatic run_op(input int unit, input int d, input int xa, input int ya,
                          input int xb, input int yb, input int fa, input int fb,
                          output int rx, output int ry, output int rinf,
                          output int lat, output int ndone, output int bsy_first,
                          output int bsy_after);
        rx = 0; ry = 0; rinf = 0; lat = -1; ndone = 0; bsy_first = 0; bsy_after = 1;
        @(negedge clk);
        drive(d, xa, ya, xb, yb, fa, fb);
        if (unit == 0) start0 = 1'b1;
        else           start1 = 1'b1;
        for (int c = 1; c <= 600; c++) begin
            @(negedge clk);
            start0 = 1'b0;
            start1 = 1'b0;
            if (c == 1) bsy_first = int'(unit == 0 ? busy0 : busy1);
            if (unit == 0 ? done0 : done1) begin
                lat   = c;
                ndone = 1;
                rx    = int'(unit == 0 ? ox0 : ox1);
                ry    = int'(unit == 0 ? oy0 : oy1);
                rinf  = int'(unit == 0 ? oinf0 : oinf1);
                break;
            end
        end
        @(negedge clk);
        if (unit == 0 ? done0 : done1) ndone++;
        bsy_after = int'(unit == 0 ? busy0 : busy1);
    endtask

    typedef struct {
        int dbl, x1, y1, x2, y2, inf1, inf2;
        int ex, ey, einf, ereqs;
    } vec_t;

    vec_t vt[12];

    initial begin
        int rx, ry, rinf, lat, nd, bf, ba, base, dcount;
        vt[0]  = '{1,  3,  6,  0,  0, 0, 0, 80, 10, 0, 4};
        vt[1]  = '{0,  3,  6, 80, 10, 0, 0, 80, 87, 0, 3};
        vt[2]  = '{0, 80, 87, 80, 10, 0, 0,  0,  0, 1, 0};
        vt[3]  = '{0,  3,  6,  3,  6, 0, 0, 80, 10, 0, 4};
        vt[4]  = '{0,  3,  6, 80, 10, 1, 0, 80, 10, 0, 0};
        vt[5]  = '{1,  5,  0,  0,  0, 0, 0,  0,  0, 1, 0};
        vt[6]  = '{0,  3,  6,  7,  7, 0, 1,  3,  6, 0, 0};
        vt[7]  = '{0,  3,  6, 80, 10, 1, 1,  0,  0, 1, 0};
        vt[8]  = '{1,  3,  6,  0,  0, 1, 0,  0,  0, 1, 0};
        vt[9]  = '{0,  5,  0,  5,  0, 0, 0,  0,  0, 1, 0};
        vt[10] = '{0,  3,  6, 80, 87, 0, 0,  3, 91, 0, 3};
        vt[11] = '{1, 80, 10,  0,  0, 0, 0,  3, 91, 0, 4};

        rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
        a_c = W'(A); p_c = W'(P);
        drive(0, 0, 0, 0, 0, 0, 0);
        zero_w = '0; zero_b = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", int'(busy0), 0);
        check("reset_done", int'(done0), 0);
        check("reset_x", int'(ox0), 0);
        check("reset_inf", int'(oinf0), 0);
        check("reset_mul_start", int'(mul0), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            base = req_cnt;
            run_op(0, vt[i].dbl, vt[i].x1, vt[i].y1, vt[i].x2, vt[i].y2,
                   vt[i].inf1, vt[i].inf2, rx, ry, rinf, lat, nd, bf, ba);
            check($sformatf("vec%0d_x", i), rx, vt[i].ex);
            check($sformatf("vec%0d_y", i), ry, vt[i].ey);
            check($sformatf("vec%0d_inf", i), rinf, vt[i].einf);
            check($sformatf("vec%0d_done_pulses", i), nd, 1);
            check($sformatf("vec%0d_busy_during", i), bf, 1);
            check($sformatf("vec%0d_busy_after", i), ba, 0);
            check($sformatf("vec%0d_mod_requests", i), req_cnt - base, vt[i].ereqs);
            if (vt[i].ereqs == 0) check($sformatf("vec%0d_latency", i), lat, 2);
        end

        // AUTO_DOUBLE=0: P1==P2 add collapses to infinity with no modular traffic
        run_op(1, 0, 3, 6, 3, 6, 0, 0, rx, ry, rinf, lat, nd, bf, ba);
        check("noauto_inf", rinf, 1);
        check("noauto_x", rx, 0);
        check("noauto_latency", lat, 2);
        check("noauto_done_pulses", nd, 1);
        check("noauto_mod_requests", u1_reqs, 0);

        // start re-pulsed with different inputs while busy
        @(negedge clk);
        drive(1, 3, 6, 0, 0, 0, 0);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (3) @(negedge clk);
        drive(0, 1, 2, 50, 60, 0, 0);
        a_c = 5;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        dcount = 0; lat = -1; rx = 0; ry = 0; rinf = 1;
        for (int c = 0; c < 600 && lat < 0; c++) begin
            if (done0) begin
                dcount++; lat = c; rx = int'(ox0); ry = int'(oy0); rinf = int'(oinf0);
            end
            if (lat < 0) @(negedge clk);
        end
        repeat (6) begin
            @(negedge clk);
            if (done0) dcount++;
        end
        check("busy_ignore_x", rx, 80);
        check("busy_ignore_y", ry, 10);
        check("busy_ignore_inf", rinf, 0);
        check("busy_ignore_done_pulses", dcount, 1);
        check("busy_ignore_idle", int'(busy0), 0);
        a_c = W'(A);

        // reset while waiting for lambda^2
        @(negedge clk);
        drive(1, 3, 6, 0, 0, 0, 0);
        base = req_cnt;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        for (int c = 0; c < 600 && req_cnt < base + 3; c++) @(negedge clk);
        check("reset_mid_reached_xmul", req_cnt - base, 3);
        rst = 1'b1;
        #1;
        check("reset_mid_x", int'(ox0), 0);
        check("reset_mid_y", int'(oy0), 0);
        check("reset_mid_inf", int'(oinf0), 0);
        check("reset_mid_busy", int'(busy0), 0);
        check("reset_mid_mod_a", int'(ma0), 0);
        check("reset_mid_mod_b", int'(mb0), 0);
        check("reset_mid_mul_start", int'(mul0), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        dcount = 0;
        repeat (30) begin
            @(negedge clk);
            if (done0 || busy0) dcount++;
        end
        check("reset_mid_no_done_or_busy", dcount, 0);

        base = req_cnt;
        run_op(0, 0, 3, 6, 80, 10, 0, 0, rx, ry, rinf, lat, nd, bf, ba);
        check("post_reset_x", rx, 80);
        check("post_reset_y", ry, 87);
        check("post_reset_inf", rinf, 0);
        check("post_reset_done_pulses", nd, 1);
        check("post_reset_mod_requests", req_cnt - base, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
